// File: rtl/wb_mem_tester_pkg.sv
// Shared types and helpers for the Wishbone memory tester: FSM state encoding,
// word stride/byte-select constants and the per-word pattern/address functions.
package wb_mem_tester_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR     = 3'd1,
        WR_GAP = 3'd2,
        RD     = 3'd3,
        RD_GAP = 3'd4,
        FIN    = 3'd5
    } state_t;

    localparam logic [31:0] WORD_STRIDE = 32'd4;
    localparam logic [3:0]  SEL_ALL     = 4'hF;

    // Pattern for word i is simply seed + i, wrapping at 32 bits.
    function automatic logic [31:0] pattern(input logic [31:0] seed, input logic [15:0] i);
        return seed + {16'd0, i};
    endfunction

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] i);
        return base + WORD_STRIDE * {16'd0, i};
    endfunction

endpackage

// File: rtl/wb_mem_tester.sv
// Wishbone classic memory tester: writes seed+i to WORDS words, reads them back and counts mismatches.
// Define WB_MEM_TESTER_TIMEOUT_EN to compile in the per-transfer ack watchdog.
// Handshake: a transfer is presented with cyc=stb=1 and held stable until ack is sampled high
// on a rising edge while stb=1; ack at any other time is ignored.
module wb_mem_tester
    import wb_mem_tester_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h3800_0000,
    parameter int          WORDS          = 64,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] seed,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [31:0] first_err_addr,
    output logic        timeout,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output state_t      fsm_state
);

    localparam logic [15:0] LAST = 16'(WORDS - 1);

    state_t      state;
    logic [15:0] idx;
    logic [31:0] seed_q;

`ifdef WB_MEM_TESTER_TIMEOUT_EN
    localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_cnt;
`endif

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= 16'd0;
            seed_q         <= 32'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 16'd0;
            first_err_addr <= 32'd0;
            timeout        <= 1'b0;
            wbm_cyc_o      <= 1'b0;
            wbm_stb_o      <= 1'b0;
            wbm_we_o       <= 1'b0;
            wbm_sel_o      <= 4'h0;
            wbm_adr_o      <= 32'd0;
            wbm_dat_o      <= 32'd0;
`ifdef WB_MEM_TESTER_TIMEOUT_EN
            tmo_cnt        <= '0;
`endif
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        state          <= WR;
                        idx            <= 16'd0;
                        seed_q         <= seed;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= 16'd0;
                        first_err_addr <= 32'd0;
                        timeout        <= 1'b0;
                        wbm_cyc_o      <= 1'b1;
                        wbm_stb_o      <= 1'b1;
                        wbm_we_o       <= 1'b1;
                        wbm_sel_o      <= SEL_ALL;
                        wbm_adr_o      <= BASE_ADDR;
                        wbm_dat_o      <= seed;
`ifdef WB_MEM_TESTER_TIMEOUT_EN
                        tmo_cnt        <= '0;
`endif
                    end
                end

                WR, RD: begin
                    if (wbm_ack_i) begin
                        state     <= (state == WR) ? WR_GAP : RD_GAP;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= 4'h0;
                        wbm_adr_o <= 32'd0;
                        wbm_dat_o <= 32'd0;
                        // Read check happens in the ack cycle; first_err_addr latches only the first miss.
                        if (state == RD && wbm_dat_i != pattern(seed_q, idx)) begin
                            if (err_count != 16'hFFFF)
                                err_count <= err_count + 16'd1;
                            if (err_count == 16'd0)
                                first_err_addr <= wbm_adr_o;
                        end
                    end
`ifdef WB_MEM_TESTER_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        state     <= FIN;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        timeout   <= 1'b1;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= 4'h0;
                        wbm_adr_o <= 32'd0;
                        wbm_dat_o <= 32'd0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end

                WR_GAP: begin
                    wbm_cyc_o <= 1'b1;
                    wbm_stb_o <= 1'b1;
                    wbm_sel_o <= SEL_ALL;
`ifdef WB_MEM_TESTER_TIMEOUT_EN
                    tmo_cnt   <= '0;
`endif
                    if (idx == LAST) begin
                        state     <= RD;
                        idx       <= 16'd0;
                        wbm_we_o  <= 1'b0;
                        wbm_adr_o <= BASE_ADDR;
                        wbm_dat_o <= 32'd0;
                    end else begin
                        state     <= WR;
                        idx       <= idx + 16'd1;
                        wbm_we_o  <= 1'b1;
                        wbm_adr_o <= word_addr(BASE_ADDR, idx + 16'd1);
                        wbm_dat_o <= pattern(seed_q, idx + 16'd1);
                    end
                end

                RD_GAP: begin
                    if (idx == LAST) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == 16'd0) && !timeout;
                    end else begin
                        state     <= RD;
                        idx       <= idx + 16'd1;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= SEL_ALL;
                        wbm_adr_o <= word_addr(BASE_ADDR, idx + 16'd1);
                        wbm_dat_o <= 32'd0;
`ifdef WB_MEM_TESTER_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
